pipelined_csel_adder: RTL
=========================

Name: pipelined_csel_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor; successor to the fixed 64-bit combinational carry-select adder.
- Splits a WIDTH-bit operation into SEG-bit segments. Each segment computes dual sums (cin=0 / cin=1); the carry selects between them.
- Segment groups are spread over STAGES register stages, with a valid/ready handshake on both sides.
- Sits in the execute path as the ALU add/sub/compare unit.

Parameters:
WIDTH, 64, operand/result width; must be a multiple of SEG.
SEG, 8, carry-select segment width; NSEG = WIDTH/SEG.
STAGES, 2, pipeline register stages, >=1; NSEG must be a multiple of STAGES.

Ports:
i_clk_1  in  1  clock, rising edge.
i_rstN_1  in  1  reset, asynchronous, active-low.
i_valid_1  in  1  input operation valid.
o_ready_1  out  1  unit can accept an input this cycle.
i_sub_1  in  1  1 = subtract (op1 - op2), 0 = add.
i_cIn_1  in  1  carry-in for add; ignored when i_sub_1=1.
i_adderOperand1  in  WIDTH  operand 1.
i_adderOperand2  in  WIDTH  operand 2.
o_valid_1  out  1  result valid.
i_ready_1  in  1  downstream accepts result.
o_adderSum  out  WIDTH  sum/difference, mod 2^WIDTH.
o_cOut_1  out  1  carry out of the MSB; for subtract, 1 = no borrow.
o_ovf_1  out  1  signed two's-complement overflow.
o_zero_1  out  1  o_adderSum == 0.

Behaviour:
- Effective operands:
  - Subtract: B' = ~op2, cin' = 1.
  - Add: B' = op2, cin' = i_cIn_1.
- Transfers:
  - Input transfer when i_valid_1 && o_ready_1.
  - Output transfer when o_valid_1 && i_ready_1.
- Stall rule: en = !o_valid_1 || i_ready_1; o_ready_1 = en. All stages advance together when en=1 and hold when en=0. No bubble collapsing is required.
- Stage s (0..STAGES-1) resolves segments s*G .. s*G+G-1, where G = NSEG/STAGES.
  - Each segment computes sum0/sum1 and cout0/cout1 and selects by the incoming carry, rippling through the G segments.
  - Carry into the stage's first segment: cin' for s=0, otherwise the carry registered by stage s-1.
- Each stage register holds:
  - valid bit;
  - resolved low sum bits;
  - unresolved high operand bits (op1, B');
  - running carry;
  - MSB operand signs needed for the overflow flag.
- Latency: a result accepted at edge N is presented on o_valid_1 after edge N+STAGES-1 (visible in the cycle after the STAGES-th edge). Throughput is 1 op/cycle with no stalls.
- o_ovf_1 = (a[W-1] == B'[W-1]) && (sum[W-1] != a[W-1]).
- o_zero_1 is computed from the final-stage sum and is valid only with o_valid_1.
- Outputs are registered in the last stage; no combinational input-to-output path except o_ready_1 from i_ready_1.
- Reset (asynchronous assert, any cycle, including mid-operation):
  - all stage valid bits = 0;
  - o_valid_1 = 0, o_adderSum = 0, o_cOut_1 = 0, o_ovf_1 = 0, o_zero_1 = 0;
  - o_ready_1 = 1 once reset is deasserted.
  - In-flight ops are discarded and no result emerges for them.
- Back-pressure:
  - While o_valid_1=1 and i_ready_1=0, all outputs hold stable and o_ready_1 = 0.
  - Inputs presented in that cycle are not captured.
- Bubbles: an invalid input still advances with en; its data is don't-care, but it must not raise o_valid_1.
- Simultaneous output and input transfer in the same cycle is legal and sustains full throughput.
- Wrap-around: add results are mod 2^WIDTH, with the carry reported in o_cOut_1.

Test Plan:
(WIDTH=64, SEG=8, STAGES=2 unless stated.)
1. Add 0xFFFF_FFFF_FFFF_FFFF + 0x1, cin=0 -> sum 0, cOut 1, zero 1, ovf 0, 2 cycles after accept.
2. Sub 0x5 - 0x7 -> sum 0xFFFF_FFFF_FFFF_FFFE, cOut 0 (borrow), ovf 0.
   Then sub 0x8000_0000_0000_0000 - 0x1 -> sum 0x7FFF_FFFF_FFFF_FFFF, cOut 1, ovf 1.
3. Carry across a stage boundary: 0x0000_0000_FFFF_FFFF + 0x1, cin=1 -> sum 0x0000_0001_0000_0001, cOut 0.
4. Streaming and back-pressure:
   - Stream 10 back-to-back random ops with i_ready_1=1 -> 10 results in order, 1 per cycle.
   - Drop i_ready_1 for 3 cycles mid-stream -> outputs held, o_ready_1=0, no loss or duplication; matches the reference model.
5. Assert i_rstN_1 with 2 ops in flight -> o_valid_1 drops immediately and all outputs are 0. After release, a new add 3+4 -> 7.
6. Re-run scenarios 1-4 with WIDTH=32, SEG=4, STAGES=4 and STAGES=1 -> latency 4 and 1 respectively, results match the model.

Source files
------------

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select add/sub: STAGES register stages, each resolving NSEG/STAGES segments; result after STAGES edges.
// Back-pressure: all stages advance together when the output is empty or taken (o_ready_1 = !o_valid_1 || i_ready_1).
module pipelined_csel_adder #(
    parameter int WIDTH  = 64,
    parameter int SEG    = 8,
    parameter int STAGES = 2
) (
    input  logic             i_clk_1,
    input  logic             i_rstN_1,
    input  logic             i_valid_1,
    output logic             o_ready_1,
    input  logic             i_sub_1,
    input  logic             i_cIn_1,
    input  logic [WIDTH-1:0] i_adderOperand1,
    input  logic [WIDTH-1:0] i_adderOperand2,
    output logic             o_valid_1,
    input  logic             i_ready_1,
    output logic [WIDTH-1:0] o_adderSum,
    output logic             o_cOut_1,
    output logic             o_ovf_1,
    output logic             o_zero_1
);
    localparam int NSEG = WIDTH / SEG;
    localparam int G    = NSEG / STAGES;
    localparam int GW   = G * SEG;

    logic en;

    assign en        = !g_stage[STAGES-1].vld_q || i_ready_1;
    assign o_ready_1 = en;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * GW;
        localparam int HI = LO + GW;

        logic              vld_in;
        logic              cry_in;
        logic [WIDTH-1:LO] a_in;
        logic [WIDTH-1:LO] b_in;
        logic [GW-1:0]     seg_sum;
        logic              cry_out;
        logic [HI-1:0]     sum_d;
        logic [SEG:0]      sum0;
        logic [SEG:0]      sum1;

        logic              vld_q;
        logic              cry_q;
        logic [HI-1:0]     sum_q;

        if (s == 0) begin : g_first
            assign vld_in = i_valid_1;
            assign cry_in = i_sub_1 | i_cIn_1;
            assign a_in   = i_adderOperand1;
            assign b_in   = i_sub_1 ? ~i_adderOperand2 : i_adderOperand2;
            assign sum_d  = seg_sum;
        end else begin : g_chain
            assign vld_in = g_stage[s-1].vld_q;
            assign cry_in = g_stage[s-1].cry_q;
            assign a_in   = g_stage[s-1].g_mid.a_q;
            assign b_in   = g_stage[s-1].g_mid.b_q;
            assign sum_d  = {seg_sum, g_stage[s-1].sum_q};
        end

        // Both candidate sums are formed per segment; the rippling carry only drives the muxes.
        always_comb begin
            seg_sum = '0;
            cry_out = cry_in;
            sum0    = '0;
            sum1    = '0;
            for (int g = 0; g < G; g++) begin
                sum0 = {1'b0, a_in[LO+g*SEG +: SEG]} + {1'b0, b_in[LO+g*SEG +: SEG]};
                sum1 = {1'b0, a_in[LO+g*SEG +: SEG]} + {1'b0, b_in[LO+g*SEG +: SEG]}
                       + (SEG+1)'(1);
                seg_sum[g*SEG +: SEG] = cry_out ? sum1[SEG-1:0] : sum0[SEG-1:0];
                cry_out               = cry_out ? sum1[SEG]     : sum0[SEG];
            end
        end

        always_ff @(posedge i_clk_1 or negedge i_rstN_1) begin
            if (!i_rstN_1) begin
                vld_q <= 1'b0;
                cry_q <= 1'b0;
                sum_q <= '0;
            end else if (en) begin
                vld_q <= vld_in;
                cry_q <= cry_out;
                sum_q <= sum_d;
            end
        end

        if (s < STAGES-1) begin : g_mid
            // Only the still-unresolved upper operand bits travel on; their MSBs feed the overflow flag.
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] b_q;

            always_ff @(posedge i_clk_1 or negedge i_rstN_1) begin
                if (!i_rstN_1) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_in[WIDTH-1:HI];
                    b_q <= b_in[WIDTH-1:HI];
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic zero_q;

            always_ff @(posedge i_clk_1 or negedge i_rstN_1) begin
                if (!i_rstN_1) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en) begin
                    ovf_q  <= (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum_d[WIDTH-1] != a_in[WIDTH-1]);
                    zero_q <= (sum_d == '0);
                end
            end
        end
    end

    assign o_valid_1  = g_stage[STAGES-1].vld_q;
    assign o_adderSum = g_stage[STAGES-1].sum_q;
    assign o_cOut_1   = g_stage[STAGES-1].cry_q;
    assign o_ovf_1    = g_stage[STAGES-1].g_last.ovf_q;
    assign o_zero_1   = g_stage[STAGES-1].g_last.zero_q;

endmodule
